// File: rtl/i2c_xfer_arbiter.sv
// rtl/i2c_xfer_arbiter.sv - round-robin transaction arbiter that expands register reads/writes into I2C byte commands
// Two requesters post single-register transactions; the granted one is sequenced through START..STOP with NACK/timeout aborts.

module i2c_xfer_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] rw,
    input  logic [6:0] slv_adr0,
    input  logic [6:0] slv_adr1,
    input  logic [7:0] reg_adr0,
    input  logic [7:0] reg_adr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [7:0] rdata,
    output logic [1:0] status,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [7:0] cmd_byte,
    output logic       cmd_nack,
    input  logic       cmd_done,
    input  logic       cmd_ack,
    input  logic [7:0] rx_byte
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADR_W, S_REG, S_DATA, S_RSTART,
        S_ADR_R, S_READ, S_STOP, S_DONE, S_ABORT
    } state_t;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WRITE   = 3'b001;
    localparam logic [2:0] CMD_READ    = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

    localparam logic [15:0] TICK_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    state_t      ok_state;
    logic [1:0]  nack_code;
    logic        sel;
    logic        last;
    logic        pick;
    logic        cur_rw;
    logic [6:0]  cur_adr;
    logic [7:0]  cur_reg;
    logic [7:0]  cur_wdata;
    logic [15:0] tcnt;

    // Both requesting: the port not served last wins; otherwise the lone requester.
    assign pick = (req == 2'b11) ? ~last : req[1];

    always_comb begin
        state_nxt = state;
        ok_state  = state;
        nack_code = 2'b00;
        cmd_valid = 1'b0;
        cmd       = CMD_START;
        cmd_byte  = 8'h00;
        cmd_nack  = 1'b0;
        grant     = 2'b00;
        done      = 2'b00;
        if (state != S_IDLE) begin
            grant = sel ? 2'b10 : 2'b01;
        end
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                cmd_valid = 1'b1;
                cmd       = CMD_START;
                ok_state  = S_ADR_W;
            end
            S_ADR_W: begin
                cmd_valid = 1'b1;
                cmd       = CMD_WRITE;
                cmd_byte  = {cur_adr, 1'b0};
                ok_state  = S_REG;
                nack_code = 2'b01;
            end
            S_REG: begin
                cmd_valid = 1'b1;
                cmd       = CMD_WRITE;
                cmd_byte  = cur_reg;
                ok_state  = cur_rw ? S_RSTART : S_DATA;
                nack_code = 2'b10;
            end
            S_DATA: begin
                cmd_valid = 1'b1;
                cmd       = CMD_WRITE;
                cmd_byte  = cur_wdata;
                ok_state  = S_STOP;
                nack_code = 2'b10;
            end
            S_RSTART: begin
                cmd_valid = 1'b1;
                cmd       = CMD_RESTART;
                ok_state  = S_ADR_R;
            end
            S_ADR_R: begin
                cmd_valid = 1'b1;
                cmd       = CMD_WRITE;
                cmd_byte  = {cur_adr, 1'b1};
                ok_state  = S_READ;
                nack_code = 2'b01;
            end
            S_READ: begin
                cmd_valid = 1'b1;
                cmd       = CMD_READ;
                cmd_nack  = 1'b1;
                ok_state  = S_STOP;
            end
            S_STOP: begin
                cmd_valid = 1'b1;
                cmd       = CMD_STOP;
                ok_state  = S_DONE;
            end
            S_DONE: begin
                done      = grant;
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Any NACK or timeout still routes through STOP so the bus is released.
        if (cmd_valid) begin
            if (cmd_done) begin
                state_nxt = (nack_code != 2'b00 && !cmd_ack) ? S_STOP : ok_state;
            end else if (tcnt == TICK_LAST) begin
                state_nxt = (state == S_STOP) ? S_ABORT : S_STOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            cur_rw    <= 1'b0;
            cur_adr   <= 7'h00;
            cur_reg   <= 8'h00;
            cur_wdata <= 8'h00;
            rdata     <= 8'h00;
            status    <= 2'b00;
            tcnt      <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                tcnt <= 16'h0000;
            end else if (!cmd_done) begin
                tcnt <= tcnt + 16'd1;
            end
            if (state == S_IDLE && |req) begin
                sel       <= pick;
                last      <= pick;
                cur_rw    <= rw[pick];
                cur_adr   <= pick ? slv_adr1 : slv_adr0;
                cur_reg   <= pick ? reg_adr1 : reg_adr0;
                cur_wdata <= pick ? wdata1 : wdata0;
                status    <= 2'b00;
            end
            if (cmd_valid && cmd_done) begin
                if (nack_code != 2'b00 && !cmd_ack) begin
                    status <= nack_code;
                end
                if (state == S_READ) begin
                    rdata <= rx_byte;
                end
            end else if (cmd_valid && tcnt == TICK_LAST) begin
                status <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// tb/tb_i2c_xfer_arbiter.sv - self-checking bench for i2c_xfer_arbiter with a slave/engine model
// Slave acks any address except 0x22, registers 0..15, all data; read returns reg ^ 0x5F.

module tb_i2c_xfer_arbiter;

    localparam logic [2:0] C_START = 3'd0, C_WRITE = 3'd1, C_READ = 3'd2, C_STOP = 3'd3, C_RESTART = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00, rw = 2'b00;
    logic [6:0] slv_adr0 = '0, slv_adr1 = '0;
    logic [7:0] reg_adr0 = '0, reg_adr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0] grant, done, status;
    logic [7:0] rdata, cmd_byte;
    logic       cmd_valid, cmd_nack;
    logic [2:0] cmd;
    logic       cmd_done = 1'b0, cmd_ack = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    i2c_xfer_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw),
        .slv_adr0(slv_adr0), .slv_adr1(slv_adr1), .reg_adr0(reg_adr0), .reg_adr1(reg_adr1),
        .wdata0(wdata0), .wdata1(wdata1), .grant(grant), .done(done), .rdata(rdata),
        .status(status), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_byte(cmd_byte),
        .cmd_nack(cmd_nack), .cmd_done(cmd_done), .cmd_ack(cmd_ack), .rx_byte(rx_byte)
    );

    always #5 clk = ~clk;

    // Engine + slave model
    bit         eng_on = 1'b0;
    int         eng_lat_max = 0;
    int         eng_wait = 0;
    int         eng_blk_byte = -1;
    bit         eng_blk_stop = 1'b0;
    int         eng_phase = 0;
    logic [7:0] eng_reg = 8'h00;
    logic [11:0] log_q[$];

    always @(negedge clk) begin
        cmd_done = 1'b0;
        cmd_ack  = 1'($urandom_range(1, 0));
        rx_byte  = 8'($urandom);
        if (eng_on && cmd_valid) begin
            if (eng_wait > 0) begin
                eng_wait--;
            end else if (!((cmd == C_WRITE && eng_blk_byte >= 0 && cmd_byte == eng_blk_byte[7:0]) ||
                           (cmd == C_STOP && eng_blk_stop))) begin
                cmd_done = 1'b1;
                cmd_ack  = 1'b0;
                log_q.push_back({cmd_nack, cmd, cmd_byte});
                if (cmd == C_START || cmd == C_RESTART) eng_phase = 0;
                if (cmd == C_WRITE) begin
                    if (eng_phase == 0) cmd_ack = (cmd_byte[7:1] != 7'h22);
                    else if (eng_phase == 1) begin
                        cmd_ack = (cmd_byte <= 8'd15);
                        eng_reg = cmd_byte;
                    end else cmd_ack = 1'b1;
                    eng_phase++;
                end
                if (cmd == C_READ) rx_byte = eng_reg ^ 8'h5F;
                eng_wait = $urandom_range(eng_lat_max, 0);
            end
        end
    end

    // Reference model: expected command stream and result of one transaction
    logic [11:0] exp_q[$];
    logic [1:0]  exp_st;
    logic [7:0]  model_rdata = 8'h00;
    int          model_last = 1;

    function automatic void model(input bit r, input logic [6:0] a, input logic [7:0] g, input logic [7:0] w);
        exp_q.delete();
        exp_q.push_back({1'b0, C_START, 8'h00});
        exp_q.push_back({1'b0, C_WRITE, a, 1'b0});
        if (a == 7'h22) begin
            exp_q.push_back({1'b0, C_STOP, 8'h00});
            exp_st = 2'b01;
            return;
        end
        exp_q.push_back({1'b0, C_WRITE, g});
        if (g > 8'd15) begin
            exp_q.push_back({1'b0, C_STOP, 8'h00});
            exp_st = 2'b10;
            return;
        end
        if (!r) begin
            exp_q.push_back({1'b0, C_WRITE, w});
        end else begin
            exp_q.push_back({1'b0, C_RESTART, 8'h00});
            exp_q.push_back({1'b0, C_WRITE, a, 1'b1});
            exp_q.push_back({1'b1, C_READ, 8'h00});
            model_rdata = g ^ 8'h5F;
        end
        exp_q.push_back({1'b0, C_STOP, 8'h00});
        exp_st = 2'b00;
    endfunction

    function automatic string q2s(input logic [11:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%03x ", q[i])};
        return s;
    endfunction

    function automatic bit stream_ok();
        if (log_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic set_port(input int p, input bit r, input logic [6:0] a, input logic [7:0] g, input logic [7:0] w);
        rw[p] = r;
        if (p == 0) begin slv_adr0 = a; reg_adr0 = g; wdata0 = w; end
        else begin slv_adr1 = a; reg_adr1 = g; wdata1 = w; end
    endtask

    // Post one transaction on port p alone and wait for its done pulse.
    task automatic launch(input int p, input bit r, input logic [6:0] a, input logic [7:0] g, input logic [7:0] w,
                          output bit ok, output int port, output logic [1:0] gb, output logic [7:0] rd,
                          output logic [1:0] st, output int cyc);
        logic [1:0] gprev;
        @(negedge clk);
        set_port(p, r, a, g, w);
        log_q.delete();
        model(r, a, g, w);
        req = (p == 0) ? 2'b01 : 2'b10;
        ok = 1'b0; port = -1; gb = 2'b00; rd = 8'h00; st = 2'b00; cyc = 0;
        gprev = 2'b00;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            cyc++;
            if (|done) begin
                ok = 1'b1; port = done[1] ? 1 : 0; gb = gprev; rd = rdata; st = status;
            end
            gprev = grant;
        end
        req = 2'b00;
        if (ok) model_last = port;
    endtask

    task automatic test_reset();
        eng_on = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({grant, done, rdata, status, cmd_valid, cmd, cmd_byte, cmd_nack} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got grant=%b done=%b rdata=%h status=%b vld=%b cmd=%b byte=%h nack=%b want all zero",
                     grant, done, rdata, status, cmd_valid, cmd, cmd_byte, cmd_nack);
        end
        reset = 1'b0;
        eng_on = 1'b1;
    endtask

    task automatic test_write();
        bit ok; int port, cyc; logic [1:0] gb, st; logic [7:0] rd;
        eng_lat_max = 0;
        launch(0, 1'b0, 7'h10, 8'h05, 8'hA5, ok, port, gb, rd, st, cyc);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL write_done got no done want done within 400 cycles"); end
        vectors++;
        if (!stream_ok()) begin miscompares++; $display("FAIL write_stream got %s want %s", q2s(log_q), q2s(exp_q)); end
        vectors++;
        if (st !== 2'b00 || port != 0 || gb !== 2'b01) begin
            miscompares++; $display("FAIL write_result got status=%b port=%0d grant=%b want 00 0 01", st, port, gb);
        end
        vectors++;
        if (cyc + 1 != 7) begin miscompares++; $display("FAIL write_latency got %0d cycles want 7", cyc + 1); end
    endtask

    task automatic test_read();
        bit ok; int port, cyc; logic [1:0] gb, st; logic [7:0] rd;
        eng_lat_max = 0;
        launch(1, 1'b1, 7'h10, 8'h03, 8'h00, ok, port, gb, rd, st, cyc);
        vectors++;
        if (!ok || !stream_ok()) begin
            miscompares++; $display("FAIL read_stream got ok=%b %s want %s", ok, q2s(log_q), q2s(exp_q));
        end
        vectors++;
        if (rd !== 8'h5C || st !== 2'b00 || port != 1 || gb !== 2'b10) begin
            miscompares++;
            $display("FAIL read_result got rdata=%h status=%b port=%0d grant=%b want 5c 00 1 10", rd, st, port, gb);
        end
        vectors++;
        if (cyc + 1 != 9) begin miscompares++; $display("FAIL read_latency got %0d cycles want 9", cyc + 1); end
    endtask

    task automatic test_nack();
        bit ok; int port, cyc; logic [1:0] gb, st; logic [7:0] rd;
        eng_lat_max = 1;
        launch(0, 1'b0, 7'h22, 8'h05, 8'h11, ok, port, gb, rd, st, cyc);
        vectors++;
        if (!ok || st !== 2'b01 || !stream_ok() || log_q.size() != 3) begin
            miscompares++; $display("FAIL adr_nack got ok=%b status=%b %s want 01 %s", ok, st, q2s(log_q), q2s(exp_q));
        end
        launch(1, 1'b1, 7'h10, 8'h20, 8'h00, ok, port, gb, rd, st, cyc);
        vectors++;
        if (!ok || st !== 2'b10 || !stream_ok()) begin
            miscompares++; $display("FAIL reg_nack got ok=%b status=%b %s want 10 %s", ok, st, q2s(log_q), q2s(exp_q));
        end
        vectors++;
        if (rd !== 8'h5C) begin miscompares++; $display("FAIL reg_nack_rdata got %h want 5c", rd); end
    endtask

    task automatic test_random();
        bit ok; int port, cyc, p; logic [1:0] gb, st; logic [7:0] rd; logic [6:0] a; bit r;
        eng_lat_max = 3;
        for (int n = 0; n < 24; n++) begin
            p = $urandom_range(1, 0);
            r = 1'($urandom_range(1, 0));
            case ($urandom_range(2, 0))
                0: a = 7'h10;
                1: a = 7'h22;
                default: a = 7'($urandom);
            endcase
            launch(p, r, a, 8'($urandom_range(31, 0)), 8'($urandom), ok, port, gb, rd, st, cyc);
            vectors++;
            if (!ok || !stream_ok() || port != p) begin
                miscompares++;
                $display("FAIL random_stream[%0d] got ok=%b port=%0d %s want port=%0d %s", n, ok, port, q2s(log_q), p, q2s(exp_q));
            end
            vectors++;
            if (st !== exp_st || rd !== model_rdata) begin
                miscompares++;
                $display("FAIL random_result[%0d] got status=%b rdata=%h want %b %h", n, st, rd, exp_st, model_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit tr[2]; logic [6:0] ta[2]; logic [7:0] tg[2], tw[2];
        int left[2], total, bad, exp_next, p;
        eng_lat_max = 2;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tr[i] = 1'($urandom_range(1, 0)); ta[i] = 7'h10; tg[i] = 8'($urandom_range(15, 0)); tw[i] = 8'($urandom);
            set_port(i, tr[i], ta[i], tg[i], tw[i]);
            left[i] = 2;
        end
        log_q.delete();
        req = 2'b11;
        exp_next = 1 - model_last;
        total = 0; bad = 0;
        for (int c = 0; c < 600 && total < 4; c++) begin
            @(negedge clk);
            if (grant == 2'b11) bad++;
            if (|done) begin
                p = done[1] ? 1 : 0;
                model(tr[p], ta[p], tg[p], tw[p]);
                vectors++;
                if (p != exp_next) begin miscompares++; $display("FAIL b2b_order[%0d] got port %0d want %0d", total, p, exp_next); end
                vectors++;
                if (!stream_ok() || status !== exp_st || rdata !== model_rdata) begin
                    miscompares++;
                    $display("FAIL b2b_result[%0d] got status=%b rdata=%h %s want %b %h %s",
                             total, status, rdata, q2s(log_q), exp_st, model_rdata, q2s(exp_q));
                end
                model_last = p;
                left[p]--;
                exp_next = (left[1 - p] > 0) ? 1 - p : p;
                if (left[p] > 0) begin
                    tr[p] = 1'($urandom_range(1, 0)); tg[p] = 8'($urandom_range(15, 0)); tw[p] = 8'($urandom);
                    set_port(p, tr[p], ta[p], tg[p], tw[p]);
                end else req[p] = 1'b0;
                log_q.delete();
                total++;
            end
        end
        req = 2'b00;
        vectors++;
        if (total != 4 || bad != 0) begin
            miscompares++; $display("FAIL b2b_grants got %0d dones, %0d cycles with grant=11 want 4 and 0", total, bad);
        end
    endtask

    task automatic test_timeout();
        int nr, ns, na; bit got; logic [1:0] st; logic [7:0] rd;
        for (int part = 0; part < 2; part++) begin
            @(negedge clk);
            eng_lat_max = 0; eng_blk_byte = 8'h07; eng_blk_stop = (part == 1);
            log_q.delete();
            set_port(0, 1'(part), 7'h10, 8'h07, 8'h3C);
            req = 2'b01;
            nr = 0; ns = 0; na = 0; got = 1'b0; st = 2'b00; rd = 8'h00;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                if (|done) begin got = 1'b1; st = status; rd = rdata; end
                else if (cmd_valid && cmd == C_WRITE && cmd_byte == 8'h07) nr++;
                else if (cmd_valid && cmd == C_STOP) ns++;
                else if (!cmd_valid && grant != 2'b00) na++;
            end
            req = 2'b00; eng_blk_byte = -1; eng_blk_stop = 1'b0;
            model_last = 0;
            vectors++;
            if (!got || st !== 2'b11) begin miscompares++; $display("FAIL timeout_status[%0d] got done=%b status=%b want 1 11", part, got, st); end
            vectors++;
            if (nr != 16 || ns != (part ? 16 : 1) || na != part) begin
                miscompares++;
                $display("FAIL timeout_cycles[%0d] got reg=%0d stop=%0d abort=%0d want 16 %0d %0d", part, nr, ns, na, part ? 16 : 1, part);
            end
            vectors++;
            if (rd !== model_rdata || log_q.size() != (part ? 2 : 3)) begin
                miscompares++;
                $display("FAIL timeout_misc[%0d] got rdata=%h ncmd=%0d want %h %0d", part, rd, log_q.size(), model_rdata, part ? 2 : 3);
            end
        end
    endtask

    task automatic test_reset_mid_data();
        bit hit = 1'b0;
        @(negedge clk);
        eng_lat_max = 0; eng_blk_byte = 8'hA5;
        set_port(1, 1'b0, 7'h10, 8'h05, 8'hA5);
        req = 2'b10;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (cmd_valid && cmd == C_WRITE && cmd_byte == 8'hA5) hit = 1'b1;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1; eng_on = 1'b0;
        @(negedge clk);
        vectors++;
        if (!hit || {grant, done, rdata, status, cmd_valid, cmd, cmd_byte, cmd_nack} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_mid_data got hit=%b grant=%b done=%b rdata=%h status=%b vld=%b cmd=%b byte=%h want 1 and zeros",
                     hit, grant, done, rdata, status, cmd_valid, cmd, cmd_byte);
        end
        req = 2'b11;
        @(negedge clk);
        reset = 1'b0; eng_blk_byte = -1; eng_wait = 0; eng_on = 1'b1;
        model_last = 1; model_rdata = 8'h00;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (grant != 2'b00) hit = 1'b1;
        end
        vectors++;
        if (grant !== 2'b01) begin miscompares++; $display("FAIL reset_arb got grant=%b want 01", grant); end
        req = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
